// File: rtl/ddr4_v2_2_24_tg_victim_check.sv
// Read-side checker for traffic-generator victim/aggressor patterns.
// Expected words are queued from the write-side generator. Each returned read
// word is compared against the head of that queue, pin by pin and beat by beat,
// through a three-stage pipeline.
// Handshake: the expected word is taken on a clock edge where exp_valid and
// exp_ready are both high. exp_ready is registered and never depends on
// exp_valid. rd_valid has no backpressure: a read word is consumed only when
// chk_en is high, the FSM is in RUN and the queue holds a word. A read that
// arrives while the queue is empty is dropped and flagged as an underflow.
module ddr4_v2_2_24_tg_victim_check #(
  parameter int TCQ            = 100,
  parameter int APP_DATA_WIDTH = 576,
  parameter int NUM_DQ_PINS    = 72,
  parameter int nCK_PER_CLK    = 4,
  parameter     MEM_TYPE       = "DDR3",
  parameter     MEM_ARCH       = "ULTRASCALE",
  parameter int EXP_FIFO_DEPTH = 16,
  parameter int ERR_CNT_WIDTH  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      chk_en,
  input  logic                      chk_clear,
  input  logic                      stop_on_err,
  input  logic                      exp_valid,
  output logic                      exp_ready,
  input  logic [APP_DATA_WIDTH-1:0] exp_data,
  input  logic                      rd_valid,
  input  logic [APP_DATA_WIDTH-1:0] rd_data,
  output logic                      err_valid,
  output logic [2*nCK_PER_CLK-1:0]  err_beat,
  output logic [NUM_DQ_PINS-1:0]    err_pin_sticky,
  output logic [ERR_CNT_WIDTH-1:0]  err_cnt,
  output logic [ERR_CNT_WIDTH-1:0]  word_cnt,
  output logic [ERR_CNT_WIDTH-1:0]  first_err_idx,
  output logic                      first_err_valid,
  output logic                      chk_underflow,
  output logic                      chk_stopped
);

  localparam int NBEAT = 2 * nCK_PER_CLK;
  localparam int AW    = $clog2(EXP_FIFO_DEPTH);
  // UltraScale DDR3/DDR4 groups each byte lane's beats together in the app word.
  localparam bit US_LAYOUT = (MEM_ARCH == "ULTRASCALE") &&
                             ((MEM_TYPE == "DDR3") || (MEM_TYPE == "DDR4"));
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(EXP_FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [ERR_CNT_WIDTH-1:0] CNT_W_ONE = ERR_CNT_WIDTH'(1);

  // Reject configurations the layout and delay model cannot represent.
  if ((APP_DATA_WIDTH != NUM_DQ_PINS * NBEAT) || (TCQ < 0) ||
      (US_LAYOUT && (nCK_PER_CLK != 4))) begin : g_bad_cfg
    $error("ddr4_v2_2_24_tg_victim_check: unsupported parameter set");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_STOP} state_t;
  state_t state, state_nxt;

  logic [APP_DATA_WIDTH-1:0] fifo_mem [EXP_FIFO_DEPTH];
  logic [AW-1:0]             wr_ptr, rd_ptr;
  logic [AW:0]               fifo_cnt, fifo_cnt_nxt;
  logic                      fifo_empty, push, pop, rd_take, mismatch;

  logic                      s1_valid, s2_valid;
  logic [APP_DATA_WIDTH-1:0] s1_rd, s1_exp;
  logic [NUM_DQ_PINS-1:0]    diff_beat [NBEAT];
  logic [NBEAT-1:0]          beat_or, s2_beat;
  logic [NUM_DQ_PINS-1:0]    pin_or, s2_pin;

  assign fifo_empty  = (fifo_cnt == '0);
  assign push        = exp_valid && exp_ready;
  assign rd_take     = rd_valid && chk_en && (state == ST_RUN);
  assign pop         = rd_take && !fifo_empty;
  assign mismatch    = err_valid && (err_beat != '0);
  assign chk_stopped = (state == ST_STOP);

  // Queue occupancy after this cycle's push/pop.
  always_comb begin
    fifo_cnt_nxt = fifo_cnt;
    if (push && !pop)      fifo_cnt_nxt = fifo_cnt + CNT_ONE;
    else if (pop && !push) fifo_cnt_nxt = fifo_cnt - CNT_ONE;
  end

  // Queue pointers, occupancy and the registered ready flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
      exp_ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      fifo_cnt  <= fifo_cnt_nxt;
      exp_ready <= (fifo_cnt_nxt != CNT_FULL);
    end
  end

  // Queue storage and stage-1 data capture; data needs no reset, valids gate it.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= exp_data;
    if (pop) begin
      s1_rd  <= rd_data;
      s1_exp <= fifo_mem[rd_ptr];
    end
  end

  // De-interleave the XOR of both words into beat/pin form.
  for (genvar i = 0; i < NBEAT; i++) begin : g_beat
    for (genvar p = 0; p < NUM_DQ_PINS; p++) begin : g_pin
      localparam int BIT = US_LAYOUT ? (16 * nCK_PER_CLK) * (p / 8) + 8 * i + (p % 8)
                                     : NUM_DQ_PINS * i + p;
      assign diff_beat[i][p] = s1_rd[BIT] ^ s1_exp[BIT];
    end
  end

  // Per-beat and per-pin OR reductions of the mismatch map.
  always_comb begin
    beat_or = '0;
    pin_or  = '0;
    for (int i = 0; i < NBEAT; i++) begin
      beat_or[i] = |diff_beat[i];
      pin_or     = pin_or | diff_beat[i];
    end
  end

  // Pipeline valids and stage-2 reduction results; clear discards in-flight words.
  always_ff @(posedge clk) begin
    if (rst || chk_clear) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s2_beat  <= '0;
      s2_pin   <= '0;
    end else begin
      s1_valid <= pop;
      s2_valid <= s1_valid;
      s2_beat  <= s1_valid ? beat_or : '0;
      s2_pin   <= s1_valid ? pin_or : '0;
    end
  end

  // Stage 3: result pulse, counters, sticky flags and first-error capture.
  always_ff @(posedge clk) begin
    if (rst || chk_clear) begin
      err_valid       <= 1'b0;
      err_beat        <= '0;
      err_pin_sticky  <= '0;
      err_cnt         <= '0;
      word_cnt        <= '0;
      first_err_idx   <= '0;
      first_err_valid <= 1'b0;
      chk_underflow   <= 1'b0;
    end else begin
      err_valid <= s2_valid;
      err_beat  <= s2_valid ? s2_beat : '0;
      if (rd_take && fifo_empty) chk_underflow <= 1'b1;
      if (s2_valid) begin
        word_cnt       <= word_cnt + CNT_W_ONE;
        err_pin_sticky <= err_pin_sticky | s2_pin;
        if (s2_beat != '0) begin
          if (err_cnt != '1) err_cnt <= err_cnt + CNT_W_ONE;
          if (!first_err_valid) begin
            first_err_valid <= 1'b1;
            first_err_idx   <= word_cnt;
          end
        end
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // FSM next state: a reported mismatch stops checking only when asked to.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (chk_en) state_nxt = ST_RUN;
      ST_RUN: begin
        if (mismatch && stop_on_err && !chk_clear) state_nxt = ST_STOP;
        else if (!chk_en)                          state_nxt = ST_IDLE;
      end
      ST_STOP: if (chk_clear) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ddr4_v2_2_24_tg_victim_check.sv
// Self-checking bench for ddr4_v2_2_24_tg_victim_check (default parameters:
// UltraScale DDR layout, 72 pins, 8 beats, 16-deep expected queue).
module tb_ddr4_v2_2_24_tg_victim_check;
  localparam int W  = 576;
  localparam int NB = 8;
  localparam int NP = 72;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          chk_en = 1'b0, chk_clear = 1'b0, stop_on_err = 1'b0;
  logic          exp_valid = 1'b0, rd_valid = 1'b0;
  logic [W-1:0]  exp_data = '0, rd_data = '0;
  logic          exp_ready, err_valid, first_err_valid, chk_underflow, chk_stopped;
  logic [NB-1:0] err_beat;
  logic [NP-1:0] err_pin_sticky;
  logic [CW-1:0] err_cnt, word_cnt, first_err_idx;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [W-1:0]  fifo_q[$];   // model of the expected-word queue
  logic [NB-1:0] exp_q[$];    // scoreboard: expected err_beat per checked word
  logic [NB-1:0] obs_beat_q[$];
  int            obs_cyc_q[$];

  ddr4_v2_2_24_tg_victim_check dut (
    .clk(clk), .rst(rst), .chk_en(chk_en), .chk_clear(chk_clear),
    .stop_on_err(stop_on_err), .exp_valid(exp_valid), .exp_ready(exp_ready),
    .exp_data(exp_data), .rd_valid(rd_valid), .rd_data(rd_data),
    .err_valid(err_valid), .err_beat(err_beat), .err_pin_sticky(err_pin_sticky),
    .err_cnt(err_cnt), .word_cnt(word_cnt), .first_err_idx(first_err_idx),
    .first_err_valid(first_err_valid), .chk_underflow(chk_underflow),
    .chk_stopped(chk_stopped)
  );

  // clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // record every result pulse with the cycle it was seen in
  always @(negedge clk) begin
    if (err_valid) begin
      obs_beat_q.push_back(err_beat);
      obs_cyc_q.push_back(cyc);
    end
  end

  // reference layout: pin p of beat i lives at app bit 64*(p/8) + 8*i + p%8
  function automatic int app_pos(input int i, input int p);
    return 64 * (p / 8) + 8 * i + (p % 8);
  endfunction

  function automatic logic [NB-1:0] model_beats(input logic [W-1:0] d);
    logic [NB-1:0] b = '0;
    for (int i = 0; i < NB; i++)
      for (int p = 0; p < NP; p++)
        if (d[app_pos(i, p)]) b[i] = 1'b1;
    return b;
  endfunction

  function automatic logic [NP-1:0] model_pins(input logic [W-1:0] d);
    logic [NP-1:0] m = '0;
    for (int i = 0; i < NB; i++)
      for (int p = 0; p < NP; p++)
        if (d[app_pos(i, p)]) m[p] = 1'b1;
    return m;
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] w;
    for (int k = 0; k < W / 32; k++) w[k*32 +: 32] = $urandom();
    return w;
  endfunction

  function automatic logic [W-1:0] rand_flips();
    logic [W-1:0] m = '0;
    int n = $urandom_range(1, 3);
    for (int k = 0; k < n; k++) m[$urandom_range(0, W - 1)] = 1'b1;
    return m;
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [W-1:0] w);
    exp_valid = 1'b1;
    exp_data  = w;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (exp_ready) begin
        tick();
        exp_valid = 1'b0;
        fifo_q.push_back(w);
        return;
      end
      tick();
    end
    exp_valid = 1'b0;
    checks++;
    errors++;
    $display("FAIL push_timeout: exp_ready=%0b required 1 within 40 cycles", exp_ready);
  endtask

  // one read beat; the model consumes the queue head and predicts err_beat
  task automatic read_flip(input logic [W-1:0] flips);
    logic [W-1:0] e;
    e = fifo_q.pop_front();
    rd_valid = 1'b1;
    rd_data  = e ^ flips;
    exp_q.push_back(model_beats(flips));
    tick();
    rd_valid = 1'b0;
  endtask

  task automatic do_clear();
    chk_clear = 1'b1;
    tick();
    chk_clear = 1'b0;
    tick();
    exp_q.delete();
    obs_beat_q.delete();
    obs_cyc_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if ({exp_ready, err_valid, err_beat, first_err_valid, chk_underflow, chk_stopped} !== '0) begin
      errors++;
      $display("FAIL reset_flags: rdy=%0b ev=%0b beat=%h fev=%0b uf=%0b stop=%0b required all 0",
               exp_ready, err_valid, err_beat, first_err_valid, chk_underflow, chk_stopped);
    end
    checks++;
    if ({err_cnt, word_cnt, err_pin_sticky, first_err_idx} !== '0) begin
      errors++;
      $display("FAIL reset_counts: err_cnt=%0d word_cnt=%0d sticky=%h idx=%0d required 0",
               err_cnt, word_cnt, err_pin_sticky, first_err_idx);
    end
    tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if (exp_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: exp_ready=%0b required 1", exp_ready);
    end
    tick();
  endtask

  task automatic test_basic_match();
    int n0;
    chk_en = 1'b1;
    tick();
    do_clear();
    for (int k = 0; k < 4; k++) push_word(rand_word());
    n0 = cyc;
    for (int k = 0; k < 4; k++) read_flip('0);
    repeat (6) tick();
    checks++;
    if (obs_beat_q.size() !== 4) begin
      errors++;
      $display("FAIL basic_pulses: got %0d pulses required 4", obs_beat_q.size());
    end
    for (int k = 0; k < 4 && k < obs_beat_q.size(); k++) begin
      checks++;
      if (obs_beat_q[k] !== exp_q[k] || obs_cyc_q[k] !== n0 + k + 3) begin
        errors++;
        $display("FAIL basic_word%0d: beat=%h at cycle %0d required beat=%h at cycle %0d",
                 k, obs_beat_q[k], obs_cyc_q[k], exp_q[k], n0 + k + 3);
      end
    end
    checks++;
    if (err_cnt !== 0 || word_cnt !== 4) begin
      errors++;
      $display("FAIL basic_counts: err_cnt=%0d word_cnt=%0d required 0 and 4", err_cnt, word_cnt);
    end
  endtask

  task automatic test_pin_error();
    logic [W-1:0] f = '0;
    f[29] = 1'b1;
    do_clear();
    for (int k = 0; k < 3; k++) push_word(rand_word());
    read_flip('0);
    read_flip(f);
    read_flip('0);
    repeat (6) tick();
    checks++;
    if (obs_beat_q.size() !== 3 || obs_beat_q[1] !== 8'h08 || obs_beat_q[0] !== 8'h00) begin
      errors++;
      $display("FAIL pin_error_beats: pulses=%0d beat1=%h required 3 pulses with beat1=08",
               obs_beat_q.size(), obs_beat_q.size() > 1 ? obs_beat_q[1] : 8'hxx);
    end
    checks++;
    if (err_pin_sticky !== model_pins(f) || err_pin_sticky[5] !== 1'b1) begin
      errors++;
      $display("FAIL pin_error_sticky: sticky=%h required %h", err_pin_sticky, model_pins(f));
    end
    checks++;
    if (err_cnt !== 1 || first_err_valid !== 1'b1 || first_err_idx !== 1 || word_cnt !== 3) begin
      errors++;
      $display("FAIL pin_error_counts: err_cnt=%0d fev=%0b idx=%0d words=%0d required 1 1 1 3",
               err_cnt, first_err_valid, first_err_idx, word_cnt);
    end
  endtask

  task automatic test_random();
    logic [NP-1:0] sticky_m = '0;
    int            errs_m = 0, first_m = -1, words_m = 0;
    logic [W-1:0]  f;
    do_clear();
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 8; k++) push_word(rand_word());
      for (int k = 0; k < 8; k++) begin
        f = ($urandom_range(0, 1) == 1) ? rand_flips() : '0;
        if (f != '0) begin
          errs_m++;
          if (first_m < 0) first_m = words_m;
        end
        sticky_m = sticky_m | model_pins(f);
        words_m++;
        read_flip(f);
        repeat ($urandom_range(0, 1)) tick();
      end
    end
    repeat (6) tick();
    checks++;
    if (obs_beat_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL random_pulses: got %0d required %0d", obs_beat_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < obs_beat_q.size(); k++) begin
      checks++;
      if (obs_beat_q[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL random_word%0d: beat=%h required %h", k, obs_beat_q[k], exp_q[k]);
      end
    end
    checks++;
    if (err_cnt !== errs_m || word_cnt !== words_m || err_pin_sticky !== sticky_m) begin
      errors++;
      $display("FAIL random_counts: err=%0d words=%0d sticky=%h required %0d %0d %h",
               err_cnt, word_cnt, err_pin_sticky, errs_m, words_m, sticky_m);
    end
    checks++;
    if (first_err_valid !== (first_m >= 0) || (first_m >= 0 && first_err_idx !== first_m)) begin
      errors++;
      $display("FAIL random_first: fev=%0b idx=%0d required idx %0d", first_err_valid, first_err_idx, first_m);
    end
  endtask

  task automatic test_stop();
    int n0, seen = -1;
    do_clear();
    stop_on_err = 1'b1;
    for (int k = 0; k < 4; k++) push_word(rand_word());
    n0 = cyc;
    read_flip(rand_flips());
    for (int k = 0; k < 10 && seen < 0; k++) begin
      @(negedge clk);
      if (chk_stopped) seen = cyc;
      tick();
    end
    checks++;
    if (seen !== n0 + 4) begin
      errors++;
      $display("FAIL stop_timing: chk_stopped rose at cycle %0d required %0d", seen, n0 + 4);
    end
    for (int k = 0; k < 3; k++) begin
      rd_valid = 1'b1;
      rd_data  = rand_word();
      tick();
      rd_valid = 1'b0;
      tick();
    end
    repeat (5) tick();
    checks++;
    if (chk_stopped !== 1'b1 || word_cnt !== 1 || obs_beat_q.size() !== 1 || chk_underflow !== 1'b0) begin
      errors++;
      $display("FAIL stop_hold: stopped=%0b words=%0d pulses=%0d uf=%0b required 1 1 1 0",
               chk_stopped, word_cnt, obs_beat_q.size(), chk_underflow);
    end
    stop_on_err = 1'b0;
    do_clear();
    checks++;
    if (chk_stopped !== 1'b0 || err_cnt !== 0 || word_cnt !== 0 || first_err_valid !== 1'b0 ||
        err_pin_sticky !== '0) begin
      errors++;
      $display("FAIL stop_clear: stopped=%0b err=%0d words=%0d fev=%0b sticky=%h required all 0",
               chk_stopped, err_cnt, word_cnt, first_err_valid, err_pin_sticky);
    end
    for (int k = 0; k < 3; k++) read_flip('0);
    repeat (6) tick();
    checks++;
    if (obs_beat_q.size() !== 3 || word_cnt !== 3 || err_cnt !== 0 || chk_underflow !== 1'b0) begin
      errors++;
      $display("FAIL stop_retained: pulses=%0d words=%0d err=%0d uf=%0b required 3 3 0 0",
               obs_beat_q.size(), word_cnt, err_cnt, chk_underflow);
    end
  endtask

  task automatic test_full();
    logic [W-1:0] nw;
    int           ok = 0;
    do_clear();
    for (int k = 0; k < 16; k++) push_word(rand_word());
    @(negedge clk);
    checks++;
    if (exp_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready: exp_ready=%0b required 0 with 16 entries", exp_ready);
    end
    nw        = rand_word();
    exp_valid = 1'b1;
    exp_data  = nw;
    tick();
    read_flip('0);
    for (int k = 0; k < 5 && ok == 0; k++) begin
      @(negedge clk);
      if (exp_ready) ok = 1;
      tick();
    end
    exp_valid = 1'b0;
    fifo_q.push_back(nw);
    @(negedge clk);
    checks++;
    if (ok !== 1 || exp_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_refill: accepted=%0d exp_ready=%0b required 1 and 0 (back to 16)", ok, exp_ready);
    end
    tick();
    while (fifo_q.size() > 0) read_flip('0);
    repeat (6) tick();
    checks++;
    if (obs_beat_q.size() !== 17 || word_cnt !== 17 || err_cnt !== 0) begin
      errors++;
      $display("FAIL full_drain: pulses=%0d words=%0d err=%0d required 17 17 0",
               obs_beat_q.size(), word_cnt, err_cnt);
    end
  endtask

  task automatic test_underflow();
    do_clear();
    rd_valid = 1'b1;
    rd_data  = rand_word();
    tick();
    rd_valid = 1'b0;
    repeat (6) tick();
    checks++;
    if (chk_underflow !== 1'b1 || obs_beat_q.size() !== 0 || word_cnt !== 0) begin
      errors++;
      $display("FAIL underflow: uf=%0b pulses=%0d words=%0d required 1 0 0",
               chk_underflow, obs_beat_q.size(), word_cnt);
    end
  endtask

  task automatic test_clear_inflight();
    do_clear();
    push_word(rand_word());
    read_flip(rand_flips());
    tick();
    chk_clear = 1'b1;
    tick();
    chk_clear = 1'b0;
    repeat (5) tick();
    checks++;
    if (obs_beat_q.size() !== 0 || err_cnt !== 0 || first_err_valid !== 1'b0 || word_cnt !== 0) begin
      errors++;
      $display("FAIL clear_inflight: pulses=%0d err=%0d fev=%0b words=%0d required all 0",
               obs_beat_q.size(), err_cnt, first_err_valid, word_cnt);
    end
    exp_q.delete();
  endtask

  task automatic test_en_drop();
    do_clear();
    push_word(rand_word());
    push_word(rand_word());
    read_flip('0);
    rd_valid = 1'b1;
    rd_data  = fifo_q.pop_front() ^ {{(W-1){1'b0}}, 1'b1};
    exp_q.push_back(8'h01);
    tick();
    rd_valid = 1'b0;
    chk_en   = 1'b0;
    tick();
    rd_valid = 1'b1;
    rd_data  = rand_word();
    tick();
    rd_valid = 1'b0;
    repeat (6) tick();
    checks++;
    if (obs_beat_q.size() !== 2 || obs_beat_q[1] !== 8'h01 || chk_underflow !== 1'b0 || err_cnt !== 1) begin
      errors++;
      $display("FAIL en_drop: pulses=%0d uf=%0b err=%0d required 2 pulses, uf 0, err 1",
               obs_beat_q.size(), chk_underflow, err_cnt);
    end
    chk_en = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) push_word(rand_word());
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    obs_beat_q.delete();
    obs_cyc_q.delete();
    repeat (2) tick();
    rd_valid = 1'b1;
    rd_data  = rand_word();
    tick();
    rd_valid = 1'b0;
    repeat (6) tick();
    checks++;
    if (chk_underflow !== 1'b1 || obs_beat_q.size() !== 0 || word_cnt !== 0 || exp_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: uf=%0b pulses=%0d words=%0d rdy=%0b required 1 0 0 1",
               chk_underflow, obs_beat_q.size(), word_cnt, exp_ready);
    end
  endtask

  initial begin
    test_reset();
    test_basic_match();
    test_pin_error();
    test_random();
    test_stop();
    test_full();
    test_underflow();
    test_clear_inflight();
    test_en_drop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // global time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL time_limit: simulation did not finish within 200000 time units");
    $fatal(1, "time limit");
  end

endmodule
